// File: rtl/id_stage_if.sv
// ============================================================================
// Module      : id_stage_if
// Description : Fetch-side handshake and decoded execute-side bundle for the
//               instruction-decode stage.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface id_stage_if;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush;
  logic        ex_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_wreg;
  logic [15:0] id_imm16;
  logic        id_ext_op;
  logic        id_alu_src;
  logic [3:0]  id_alu_op;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_mem_to_reg;
  logic        id_beq;
  logic        id_bne;
  logic        id_jump;
  logic [25:0] id_jtarget;
  logic        id_illegal;

  // Stage view
  modport master (
    input  if_valid, if_instr, if_pc, flush, ex_ready,
    output if_ready, id_valid, id_pc, id_rs, id_rt, id_wreg, id_imm16,
           id_ext_op, id_alu_src, id_alu_op, id_reg_write, id_mem_read,
           id_mem_write, id_mem_to_reg, id_beq, id_bne, id_jump,
           id_jtarget, id_illegal
  );

  // Fetch / execute view
  modport slave (
    output if_valid, if_instr, if_pc, flush, ex_ready,
    input  if_ready, id_valid, id_pc, id_rs, id_rt, id_wreg, id_imm16,
           id_ext_op, id_alu_src, id_alu_op, id_reg_write, id_mem_read,
           id_mem_write, id_mem_to_reg, id_beq, id_bne, id_jump,
           id_jtarget, id_illegal
  );
endinterface

`default_nettype wire

// File: rtl/id_stage.sv
// ============================================================================
// Module      : id_stage
// Description : Instruction-decode pipeline register with valid/ready
//               handshake, stall, flush and control decode.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module id_stage #(
  parameter int ILLEGAL_TRAP = 1
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  id_stage_if.master  bus
);

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_j     = 6'b000010;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_bne   = 6'b000101;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_addiu = 6'b001001;
  localparam logic [5:0] c_op_slti  = 6'b001010;
  localparam logic [5:0] c_op_sltiu = 6'b001011;
  localparam logic [5:0] c_op_andi  = 6'b001100;
  localparam logic [5:0] c_op_ori   = 6'b001101;
  localparam logic [5:0] c_op_xori  = 6'b001110;
  localparam logic [5:0] c_op_lui   = 6'b001111;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;

  localparam logic [3:0] c_alu_add  = 4'd0;
  localparam logic [3:0] c_alu_sub  = 4'd1;
  localparam logic [3:0] c_alu_and  = 4'd2;
  localparam logic [3:0] c_alu_or   = 4'd3;
  localparam logic [3:0] c_alu_xor  = 4'd4;
  localparam logic [3:0] c_alu_nor  = 4'd5;
  localparam logic [3:0] c_alu_slt  = 4'd6;
  localparam logic [3:0] c_alu_sltu = 4'd7;
  localparam logic [3:0] c_alu_lui  = 4'd8;

  logic        r_valid;
  logic [31:0] r_pc;
  logic [4:0]  r_rs, r_rt, r_wreg;
  logic [15:0] r_imm16;
  logic        r_ext_op, r_alu_src;
  logic [3:0]  r_alu_op;
  logic        r_reg_write, r_mem_read, r_mem_write, r_mem_to_reg;
  logic        r_beq, r_bne, r_jump, r_illegal;
  logic [25:0] r_jtarget;

  logic [5:0]  w_op, w_funct;
  logic        w_rtype, w_unknown, w_illegal;
  logic        w_ext_op, w_alu_src;
  logic [3:0]  w_alu_op;
  logic        w_reg_write, w_mem_read, w_mem_write, w_mem_to_reg;
  logic        w_beq, w_bne, w_jump;
  logic        w_if_ready, w_transfer, w_clear;

  assign w_op       = bus.if_instr[31:26];
  assign w_funct    = bus.if_instr[5:0];
  assign w_if_ready = rst_n & ~bus.flush & (~r_valid | bus.ex_ready);
  assign w_transfer = bus.if_valid & w_if_ready;
  // Flush or a consumed payload with no replacement leaves a bubble
  assign w_clear    = bus.flush | (r_valid & bus.ex_ready);

  always_comb begin
    w_rtype      = 1'b0;
    w_unknown    = 1'b0;
    w_ext_op     = 1'b0;
    w_alu_src    = 1'b0;
    w_alu_op     = c_alu_add;
    w_reg_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_beq        = 1'b0;
    w_bne        = 1'b0;
    w_jump       = 1'b0;
    case (w_op)
      c_op_rtype: begin
        if (bus.if_instr != 32'd0) begin
          w_rtype     = 1'b1;
          w_reg_write = 1'b1;
          case (w_funct)
            6'b100001: w_alu_op = c_alu_add;
            6'b100011: w_alu_op = c_alu_sub;
            6'b100100: w_alu_op = c_alu_and;
            6'b100101: w_alu_op = c_alu_or;
            6'b100110: w_alu_op = c_alu_xor;
            6'b100111: w_alu_op = c_alu_nor;
            6'b101010: w_alu_op = c_alu_slt;
            6'b101011: w_alu_op = c_alu_sltu;
            default:   w_unknown = 1'b1;
          endcase
        end
      end
      c_op_addi, c_op_addiu: begin
        w_alu_src = 1'b1; w_reg_write = 1'b1; w_ext_op = 1'b1; w_alu_op = c_alu_add;
      end
      c_op_slti: begin
        w_alu_src = 1'b1; w_reg_write = 1'b1; w_ext_op = 1'b1; w_alu_op = c_alu_slt;
      end
      c_op_sltiu: begin
        w_alu_src = 1'b1; w_reg_write = 1'b1; w_ext_op = 1'b1; w_alu_op = c_alu_sltu;
      end
      c_op_andi: begin
        w_alu_src = 1'b1; w_reg_write = 1'b1; w_alu_op = c_alu_and;
      end
      c_op_ori: begin
        w_alu_src = 1'b1; w_reg_write = 1'b1; w_alu_op = c_alu_or;
      end
      c_op_xori: begin
        w_alu_src = 1'b1; w_reg_write = 1'b1; w_alu_op = c_alu_xor;
      end
      c_op_lui: begin
        w_alu_src = 1'b1; w_reg_write = 1'b1; w_alu_op = c_alu_lui;
      end
      c_op_lw: begin
        w_alu_src = 1'b1; w_ext_op = 1'b1; w_reg_write = 1'b1;
        w_mem_read = 1'b1; w_mem_to_reg = 1'b1;
      end
      c_op_sw: begin
        w_alu_src = 1'b1; w_ext_op = 1'b1; w_mem_write = 1'b1;
      end
      c_op_beq: begin
        w_ext_op = 1'b1; w_alu_op = c_alu_sub; w_beq = 1'b1;
      end
      c_op_bne: begin
        w_ext_op = 1'b1; w_alu_op = c_alu_sub; w_bne = 1'b1;
      end
      c_op_j: begin
        w_jump = 1'b1;
      end
      default: w_unknown = 1'b1;
    endcase
    // Undecodable words become an inert NOP regardless of trap mode
    if (w_unknown) begin
      w_rtype      = 1'b0;
      w_ext_op     = 1'b0;
      w_alu_src    = 1'b0;
      w_alu_op     = c_alu_add;
      w_reg_write  = 1'b0;
      w_mem_read   = 1'b0;
      w_mem_write  = 1'b0;
      w_mem_to_reg = 1'b0;
      w_beq        = 1'b0;
      w_bne        = 1'b0;
      w_jump       = 1'b0;
    end
  end

  generate
    if (ILLEGAL_TRAP != 0) begin : g_trap
      assign w_illegal = w_unknown;
    end else begin : g_no_trap
      assign w_illegal = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_wreg       <= '0;
      r_imm16      <= '0;
      r_ext_op     <= 1'b0;
      r_alu_src    <= 1'b0;
      r_alu_op     <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_beq        <= 1'b0;
      r_bne        <= 1'b0;
      r_jump       <= 1'b0;
      r_illegal    <= 1'b0;
      r_jtarget    <= '0;
    end else if (w_transfer) begin
      r_valid      <= 1'b1;
      r_pc         <= bus.if_pc;
      r_rs         <= bus.if_instr[25:21];
      r_rt         <= bus.if_instr[20:16];
      r_wreg       <= w_rtype ? bus.if_instr[15:11] : bus.if_instr[20:16];
      r_imm16      <= bus.if_instr[15:0];
      r_ext_op     <= w_ext_op;
      r_alu_src    <= w_alu_src;
      r_alu_op     <= w_alu_op;
      r_reg_write  <= w_reg_write;
      r_mem_read   <= w_mem_read;
      r_mem_write  <= w_mem_write;
      r_mem_to_reg <= w_mem_to_reg;
      r_beq        <= w_beq;
      r_bne        <= w_bne;
      r_jump       <= w_jump;
      r_illegal    <= w_illegal;
      r_jtarget    <= bus.if_instr[25:0];
    end else if (w_clear) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_beq        <= 1'b0;
      r_bne        <= 1'b0;
      r_jump       <= 1'b0;
      r_illegal    <= 1'b0;
    end
  end

  assign bus.if_ready      = w_if_ready;
  assign bus.id_valid      = r_valid;
  assign bus.id_pc         = r_pc;
  assign bus.id_rs         = r_rs;
  assign bus.id_rt         = r_rt;
  assign bus.id_wreg       = r_wreg;
  assign bus.id_imm16      = r_imm16;
  assign bus.id_ext_op     = r_ext_op;
  assign bus.id_alu_src    = r_alu_src;
  assign bus.id_alu_op     = r_alu_op;
  assign bus.id_reg_write  = r_reg_write;
  assign bus.id_mem_read   = r_mem_read;
  assign bus.id_mem_write  = r_mem_write;
  assign bus.id_mem_to_reg = r_mem_to_reg;
  assign bus.id_beq        = r_beq;
  assign bus.id_bne        = r_bne;
  assign bus.id_jump       = r_jump;
  assign bus.id_jtarget    = r_jtarget;
  assign bus.id_illegal    = r_illegal;

endmodule

`default_nettype wire
